// File: rtl/db_pkg.sv
// db_pkg: shared types and sizing helpers for the multiplexed debounce controller.
package db_pkg;
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;
  localparam int EVT_CH_W = 4;
  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic level;
  } db_evt_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/db_event_fifo.sv
// db_event_fifo: show-ahead FIFO of debounce events; a push into a full FIFO is taken only alongside a pop.
module db_event_fifo
  import db_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  db_evt_t din,
  output db_evt_t dout,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  db_evt_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] n;
  logic do_push, do_pop;
  assign empty = n == '0;
  assign full = n == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      n <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      n <= n + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/multi_debounce_ctrl.sv
// multi_debounce_ctrl: scanned early-debounce of N_CH switches with one shared engine and tick counter.
// Define DB_EVENT_FIFO_EN to build the evt_* stream; otherwise those outputs are tied to 0.
module multi_debounce_ctrl
  import db_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TICK_M = 1_000_000,
  parameter int STABLE_TICKS = 3,
  parameter int EVT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         sw,
  output logic [N_CH-1:0]         db,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ch_w(N_CH)-1:0]   evt_ch,
  output logic                    evt_level,
  output logic                    evt_ovf
);
  localparam int CW = ch_w(N_CH);
  localparam int TW = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  if (N_CH < 1 || N_CH > 16 || N_CH > TICK_M || STABLE_TICKS < 1 || STABLE_TICKS > 7 ||
      EVT_DEPTH < 2 || (EVT_DEPTH & (EVT_DEPTH - 1)) != 0) begin : g_bad_params
    $error("multi_debounce_ctrl: illegal parameter set");
  end
  logic [N_CH-1:0] s1, ss, pend;
  logic [TW-1:0] count;
  logic [CW-1:0] ptr;
  logic tick;
  db_state_t st [N_CH];
  logic [2:0] cnt [N_CH];
  db_state_t cur, nst;
  logic [2:0] ncnt;
  logic s, push, lvl;
  assign tick = count == TW'(TICK_M - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      ss <= '0;
      count <= '0;
      ptr <= '0;
    end else begin
      s1 <= sw;
      ss <= s1;
      count <= tick ? '0 : count + 1'b1;
      ptr <= (ptr == CW'(N_CH - 1)) ? '0 : ptr + 1'b1;
    end
  // Wait states swallow ss; only a completed tick count decides where the channel settles.
  always_comb begin
    cur = st[ptr];
    s = ss[ptr];
    nst = cur;
    ncnt = cnt[ptr];
    push = 1'b0;
    lvl = s;
    case (cur)
      ZERO: if (s) begin
        nst = WAIT1;
        ncnt = '0;
        push = 1'b1;
      end
      ONE: if (!s) begin
        nst = WAIT0;
        ncnt = '0;
        push = 1'b1;
      end
      default: if (pend[ptr]) begin
        ncnt = cnt[ptr] + 3'd1;
        nst = (ncnt == 3'(STABLE_TICKS)) ? (s ? ONE : ZERO) : cur;
        push = (ncnt == 3'(STABLE_TICKS)) && (s != (cur == WAIT1));
      end
    endcase
  end
  // A tick landing on the serviced channel wins over its clear, so it is never lost.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend <= '0;
      db <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st[i] <= ZERO;
        cnt[i] <= '0;
      end
    end else begin
      if (tick) pend <= '1;
      else pend[ptr] <= 1'b0;
      st[ptr] <= nst;
      cnt[ptr] <= ncnt;
      db[ptr] <= (nst == WAIT1) || (nst == ONE);
    end
`ifdef DB_EVENT_FIFO_EN
  db_evt_t evt_in, head;
  logic full, empty, pop;
  assign evt_in = '{ch: EVT_CH_W'(ptr), level: lvl};
  assign pop = evt_ready && !empty;
  db_event_fifo #(.DEPTH(EVT_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(evt_in),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign evt_valid = !empty;
  assign evt_ch = CW'(head.ch);
  assign evt_level = head.level;
  always_ff @(posedge clk or posedge reset)
    if (reset) evt_ovf <= 1'b0;
    else if (push && full && !pop) evt_ovf <= 1'b1;
`else
  logic unused_evt;
  assign unused_evt = ^{evt_ready, push, lvl};
  assign evt_valid = 1'b0;
  assign evt_ch = '0;
  assign evt_level = 1'b0;
  assign evt_ovf = 1'b0;
`endif
endmodule

// File: doc/multi_debounce_ctrl.md
# multi_debounce_ctrl

Time-multiplexed debounce controller for up to N_CH switch/button inputs on the 100 MHz board clock. It keeps per-channel early-debounce state in register arrays and services one channel per clock with a single shared update engine. A single shared tick counter paces all channels. Every change of a debounced level is reported on a valid/ready event stream to the downstream input-decode logic.

## Interface
- N_CH, 4: number of switch channels; 1..16, and N_CH <= TICK_M (elaboration assertion).
- TICK_M, 1_000_000: clk cycles per debounce tick (10 ms at 100 MHz).
- STABLE_TICKS, 3: ticks a channel holds in a wait state; 1..7.
- EVT_DEPTH, 4: event FIFO entries; power of two, >= 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sw  in  N_CH  raw asynchronous switch levels.
- db  out  N_CH  debounced levels, registered.
- evt_valid  out  1  event available at FIFO head.
- evt_ready  in  1  consumer accepts head event when evt_valid && evt_ready.
- evt_ch  out  $clog2(N_CH) (min 1)  channel of head event.
- evt_level  out  1  new db level of head event.
- evt_ovf  out  1  sticky: an event was dropped.

## Operation
- sw passes through a 2-flop synchronizer per bit; the engine sees only synchronized values (ss).
- Tick counter runs 0..TICK_M-1 and wraps. tick = (count == TICK_M-1). On tick, all N_CH pend bits are set.
- Scan pointer ptr advances 0..N_CH-1 and wraps, one channel per cycle. The engine updates only channel ptr and clears pend[ptr] when it consumes it.
- Per-channel state: st in {ZERO, WAIT1, ONE, WAIT0}; cnt counts 0..STABLE_TICKS.
- ZERO: if ss goes to WAIT1 with cnt=0, and emits an event with level 1.
- WAIT1: ss is ignored. On pend, cnt++. When cnt reaches STABLE_TICKS:
  - ss=1 goes to ONE with no event.
  - ss=0 goes to ZERO and emits an event with level 0.
- ONE: if !ss goes to WAIT0 with cnt=0, and emits an event with level 0.
- WAIT0: ss is ignored. On pend, cnt++. When cnt reaches STABLE_TICKS:
  - ss=0 goes to ZERO with no event.
  - ss=1 goes to ONE and emits an event with level 1.
- db[i] = (st[i]==WAIT1 || st[i]==ONE). The output rises or falls early, on the first serviced edge.
- At most one event per cycle, pushed into the FIFO as {ptr, level}.
- FIFO full:
  - Without a pop that cycle, the push is dropped and evt_ovf is set. evt_ovf clears only on reset.
  - A push and pop in the same cycle while full are both accepted.
- FIFO is show-ahead: evt_ch and evt_level are valid whenever evt_valid=1, and hold stable until the event is accepted.
- Reset mid-operation: all channels return to ZERO. No events are generated by reset.
- Reset values:
  - db=0, evt_valid=0, evt_ovf=0.
  - evt_ch=0, evt_level=0.
  - ptr=0, tick count=0, pend=0, synchronizers=0, FIFO empty.

## Timing
- Edge on sw[i] to db[i] change: 2 synchronizer cycles + up to N_CH cycles wait for ptr=i + 1 register cycle.
- db and the FIFO push update on the same clock edge. evt_valid rises the cycle after the push.
- Tick and consume of the same channel in the same cycle: the set wins, so pend[ptr] remains 1. Each tick is consumed exactly once per channel.
- N_CH <= TICK_M guarantees every channel is serviced between ticks, so no tick is lost.
- Hold time in a wait state is between STABLE_TICKS-1 and STABLE_TICKS tick periods, plus scan latency.

## Configuration
- DB_EVENT_FIFO_EN defined: the event FIFO and evt_* behaviour are as above.
- DB_EVENT_FIFO_EN undefined:
  - The FIFO is not instantiated.
  - evt_valid, evt_ch, evt_level and evt_ovf are tied to 0, and evt_ready is ignored.
  - db behaviour is identical.

## Structure
- Package db_pkg holds:
  - db_state_t, the enum ZERO/WAIT1/ONE/WAIT0.
  - db_evt_t, a packed struct {ch, level}.
  - the localparam function for channel-index width.
- Sub-module db_event_fifo holds the parameterized show-ahead FIFO of db_evt_t, with push/pop/full/empty. All other logic is inline.

## Test plan
All scenarios use N_CH=4, TICK_M=8, STABLE_TICKS=3, EVT_DEPTH=4.
- Reset, no sw activity for 100 cycles -> db=0, evt_valid=0, evt_ovf=0 throughout.
- sw[2] 0->1 and held -> db[2]=1 within 7 cycles; one event {ch=2, level=1}; still db[2]=1 after 40 cycles with no further event.
- sw[1] 1-cycle glitch high, then 0 -> db[1]=1 for about 2-3 ticks, then 0; events {1,1} then {1,0}.
- Bounce sw[0] every 3 cycles for 20 cycles while in WAIT1, ending high -> db[0] stays 1; single event {0,1}.
- All 4 channels toggle 0->1->0 with evt_ready=0 -> first 4 events kept in scan order; later events dropped; evt_ovf=1. Then evt_ready=1 drains exactly 4 events.
- Assert reset while channel 3 is in WAIT0 -> db=0 and FIFO empty on the reset edge; after release, sw[3]=1 produces {3,1} normally.
